// File: rtl/xalu_pkg.sv
// Shared types for the sequential slice ALU: op codes, FSM states, op legality.
// Define XALU_SUB_EN to make op 8 (SUB) legal; otherwise it reports err.
package xalu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_AND   = 4'd1,
    OP_OR    = 4'd2,
    OP_XOR   = 4'd3,
    OP_PASSA = 4'd4,
    OP_PASSB = 4'd5,
    OP_SHR   = 4'd6,
    OP_SHL   = 4'd7,
    OP_SUB   = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
`ifdef XALU_SUB_EN
    return op <= OP_SUB;
`else
    return op <= OP_SHL;
`endif
  endfunction

endpackage

// File: rtl/xalu_if.sv
// Request/response bundle between an operand source (master) and xalu_seq (slave).
interface xalu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             com;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             equ;
  logic             zero;
  logic             neg_zero;
  logic             err;

  modport master (
    output start, op, a, b, ci, com,
    input  busy, done, result, co, equ, zero, neg_zero, err
  );

  modport slave (
    input  start, op, a, b, ci, com,
    output busy, done, result, co, equ, zero, neg_zero, err
  );
endinterface

// File: rtl/xalu_slice.sv
// Combinational SLICE-bit ALU datapath; shift-in bits come from neighbouring slices.
// SUB is only built when XALU_SUB_EN is defined.
module xalu_slice
  import xalu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [3:0]       i_op,
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_shl_in,
  input  logic             i_shr_in,
  input  logic             i_com,
  output logic [SLICE-1:0] o_res,
  output logic             o_cout
);

  logic [SLICE:0]   w_sum;
  logic [SLICE:0]   w_shl;
  logic [SLICE:0]   w_shr;
  logic [SLICE-1:0] w_raw;

  assign w_shl = {i_a, i_shl_in};
  assign w_shr = {i_shr_in, i_a};

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_sum  = '0;
    w_raw  = '0;
    o_cout = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + (SLICE+1)'(i_cin);
        w_raw  = w_sum[SLICE-1:0];
        o_cout = w_sum[SLICE];
      end
`ifdef XALU_SUB_EN
      OP_SUB: begin
        w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + (SLICE+1)'(i_cin);
        w_raw  = w_sum[SLICE-1:0];
        o_cout = w_sum[SLICE];
      end
`endif
      OP_AND:   w_raw = i_a & i_b;
      OP_OR:    w_raw = i_a | i_b;
      OP_XOR:   w_raw = i_a ^ i_b;
      OP_PASSA: w_raw = i_a;
      OP_PASSB: w_raw = i_b;
      OP_SHL:   w_raw = w_shl[SLICE-1:0];
      OP_SHR:   w_raw = w_shr[SLICE:1];
      default:  w_raw = '0;
    endcase
  end

  assign o_res = i_com ? ~w_raw : w_raw;

endmodule

// File: rtl/xalu_seq.sv
// Multi-cycle ALU: runs xalu_slice once per cycle over WIDTH/SLICE chunks, LSB first.
// Define XALU_SUB_EN to enable op 8 (SUB).
module xalu_seq
  import xalu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  xalu_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int LSBW   = $clog2(WIDTH + 1);

  state_e r_state, w_state_next;

  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [3:0]       r_op;
  logic             r_ci, r_com, r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_co, r_equ, r_zero, r_neg_zero, r_err;

  logic             w_accept, w_legal, w_last;
  logic [LSBW-1:0]  w_lsb;
  logic [WIDTH:0]   w_a_lo, w_a_hi;
  logic [SLICE-1:0] w_slice_res;
  logic             w_slice_cout, w_co_final;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = bus.start && (r_state != ST_RUN);
  assign w_legal  = is_legal_op(bus.op);
  assign w_last   = (r_idx == IDXW'(NSLICE - 1));
  assign w_lsb    = LSBW'(r_idx) * LSBW'(SLICE);

  // Shift-in bits: neighbours of the current chunk, with ci entering at either end.
  assign w_a_lo = {r_a, r_ci};
  assign w_a_hi = {r_ci, r_a};

  xalu_slice #(.SLICE(SLICE)) u_slice (
    .i_op     (r_op),
    .i_a      (SLICE'(r_a >> w_lsb)),
    .i_b      (SLICE'(r_b >> w_lsb)),
    .i_cin    (r_carry),
    .i_shl_in (w_a_lo[w_lsb]),
    .i_shr_in (w_a_hi[w_lsb + LSBW'(SLICE)]),
    .i_com    (r_com),
    .o_res    (w_slice_res),
    .o_cout   (w_slice_cout)
  );

  assign w_res_next = (r_result & ~(WIDTH'({SLICE{1'b1}}) << w_lsb))
                    | (WIDTH'(w_slice_res) << w_lsb);

  always_comb begin
    w_co_final = 1'b0;
    case (r_op)
      OP_ADD:  w_co_final = w_slice_cout;
`ifdef XALU_SUB_EN
      OP_SUB:  w_co_final = w_slice_cout;
`endif
      OP_SHL:  w_co_final = r_a[WIDTH-1];
      OP_SHR:  w_co_final = r_a[0];
      default: w_co_final = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start)                w_state_next = w_legal ? ST_RUN : ST_DONE;
        else if (r_state == ST_DONE)  w_state_next = ST_IDLE;
      end
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: captured operands are reset too; they are few flops and keep the state fully defined after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_ci       <= 1'b0;
      r_com      <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_result   <= '0;
      r_co       <= 1'b0;
      r_equ      <= 1'b0;
      r_zero     <= 1'b0;
      r_neg_zero <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_op  <= bus.op;
      r_ci  <= bus.ci;
      r_com <= bus.com;
      r_idx <= '0;
      r_err <= 1'b0;
`ifdef XALU_SUB_EN
      r_carry <= (bus.op == OP_SUB) ? 1'b1 : bus.ci;
`else
      r_carry <= bus.ci;
`endif
      if (!w_legal) begin
        r_result   <= '0;
        r_co       <= 1'b0;
        r_err      <= 1'b1;
        r_equ      <= (bus.a == bus.b);
        r_zero     <= 1'b1;
        r_neg_zero <= 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      r_result <= w_res_next;
      r_carry  <= w_slice_cout;
      r_idx    <= r_idx + IDXW'(1);
      if (w_last) begin
        r_co       <= w_co_final;
        r_equ      <= (r_a == r_b);
        r_zero     <= (w_res_next == '0);
        r_neg_zero <= &w_res_next;
      end
    end
  end

  assign bus.busy     = (r_state == ST_RUN);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.result   = r_result;
  assign bus.co       = r_co;
  assign bus.equ      = r_equ;
  assign bus.zero     = r_zero;
  assign bus.neg_zero = r_neg_zero;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_xalu_seq.sv
// Directed self-checking bench for xalu_seq at WIDTH=16, SLICE=4.
module tb_xalu_seq;
  import xalu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  xalu_if #(.WIDTH(16)) bus ();

  xalu_seq #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_res"},  32'(bus.result), 0);
    check({tag, "_co"},   32'(bus.co), 0);
    check({tag, "_equ"},  32'(bus.equ), 0);
    check({tag, "_zero"}, 32'(bus.zero), 0);
    check({tag, "_nz"},   32'(bus.neg_zero), 0);
    check({tag, "_err"},  32'(bus.err), 0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic com, input int exp_lat,
                        input logic [15:0] exp_res, input logic exp_co,
                        input logic exp_equ, input logic exp_zero,
                        input logic exp_nz, input logic exp_err);
    int lat;
    logic busy1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.ci = ci; bus.com = com;
    @(posedge clk);
    lat = 0;
    busy1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 1) busy1 = bus.busy;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"},  32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy1), 32'(exp_lat > 1));
    check({tag, "_res"},  32'(bus.result), 32'(exp_res));
    check({tag, "_co"},   32'(bus.co), 32'(exp_co));
    check({tag, "_equ"},  32'(bus.equ), 32'(exp_equ));
    check({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
    check({tag, "_nz"},   32'(bus.neg_zero), 32'(exp_nz));
    check({tag, "_err"},  32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    int d1, d2, n_done;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.com = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    //          tag       op        a        b        ci  com lat res      co equ zero nz err
    run_op("add_wrap",  OP_ADD,   16'hFFFF, 16'h0001, 0, 0, 5, 16'h0000, 1, 0, 1, 0, 0);
`ifdef XALU_SUB_EN
    run_op("sub_eq",    OP_SUB,   16'h1234, 16'h1234, 0, 0, 5, 16'h0000, 1, 1, 1, 0, 0);
`else
    run_op("sub_ill",   OP_SUB,   16'h1234, 16'h1234, 0, 0, 1, 16'h0000, 0, 1, 1, 0, 1);
`endif
    run_op("shl",       OP_SHL,   16'h8001, 16'h0000, 1, 0, 5, 16'h0003, 1, 0, 0, 0, 0);
    run_op("shr",       OP_SHR,   16'h8001, 16'h0000, 0, 0, 5, 16'h4000, 1, 0, 0, 0, 0);
    run_op("xor_com",   OP_XOR,   16'h00FF, 16'h0F0F, 0, 1, 5, 16'hF00F, 0, 0, 0, 0, 0);
    run_op("illegal",   4'd9,     16'h0001, 16'h0002, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 1);
    run_op("passb",     OP_PASSB, 16'h0000, 16'hA5C3, 0, 0, 5, 16'hA5C3, 0, 0, 0, 0, 0);
    run_op("add_ci",    OP_ADD,   16'h1234, 16'h0FCD, 1, 0, 5, 16'h2202, 0, 0, 0, 0, 0);
    run_op("passa_com", OP_PASSA, 16'h00F0, 16'h1111, 0, 1, 5, 16'hFF0F, 0, 0, 0, 0, 0);
    run_op("and_ones",  OP_AND,   16'hFFFF, 16'hFFFF, 0, 0, 5, 16'hFFFF, 0, 1, 0, 1, 0);

    // Reset in the 3rd RUN cycle aborts the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h1111; bus.b = 16'h2222; bus.ci = 1'b0; bus.com = 1'b0;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 0);
    run_op("post_rst",  OP_ADD,   16'h7FFF, 16'h0001, 0, 0, 5, 16'h8000, 0, 0, 0, 0, 0);

    // Back-to-back: start held through RUN and the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h0001; bus.b = 16'h0002; bus.ci = 1'b0; bus.com = 1'b0;
    @(posedge clk);
    d1 = 0; d2 = 0; n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.op = OP_OR; bus.a = 16'h1200; bus.b = 16'h0034; end
      if (c == 6) bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        if (d1 == 0) begin
          d1 = c;
          check("b2b_add_res", 32'(bus.result), 32'h0003);
        end else if (d2 == 0) begin
          d2 = c;
          check("b2b_or_res", 32'(bus.result), 32'h1234);
        end
      end
    end
    check("b2b_first_lat", 32'(d1), 5);
    check("b2b_gap",       32'(d2 - d1), 5);
    check("b2b_n_done",    32'(n_done), 2);

    // A start pulse mid-RUN is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'h00FF; bus.b = 16'h0001; bus.ci = 1'b0; bus.com = 1'b0;
    @(posedge clk);
    d1 = 0; n_done = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.start = (c == 2);
      if (c == 2) begin bus.op = OP_OR; bus.a = 16'hAAAA; end
      if (bus.done) begin
        n_done++;
        if (d1 == 0) begin
          d1 = c;
          check("midrun_res", 32'(bus.result), 32'h0100);
        end
      end
    end
    check("midrun_lat",    32'(d1), 5);
    check("midrun_n_done", 32'(n_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
